// File: rtl/read_submitter_multi.sv
// Read-submit controller for the event buffer readout path: waits for every
// unmasked channel to be ready, issues a one-cycle read_submit and locks out.
module read_submitter_multi #(
    parameter int N_CH             = 16,
    parameter int MAX_PENDING_TIME = 1000,
    parameter int LOCK_TIME        = 30,
    parameter int CNT_W            = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             live_rising,
    input  logic [N_CH-1:0]  request,
    input  logic [N_CH-1:0]  input_mask,
    output logic             read_submit,
    output logic             pending_err,
    output logic [N_CH-1:0]  missing_mask,
    output logic [CNT_W-1:0] submit_count,
    output logic [7:0]       err_count
);

    // A zero-width counter is not representable, so both counters keep at least one bit.
    localparam int PEND_W = (MAX_PENDING_TIME > 0) ? $clog2(MAX_PENDING_TIME + 1) : 1;
    localparam int LOCK_W = (LOCK_TIME > 0) ? $clog2(LOCK_TIME + 1) : 1;

    localparam logic [PEND_W-1:0] PEND_MAX  = PEND_W'(MAX_PENDING_TIME);
    localparam logic [LOCK_W-1:0] LOCK_LAST = LOCK_W'((LOCK_TIME > 0) ? (LOCK_TIME - 1) : 0);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_WAIT   = 3'd1,
        ST_SUBMIT = 3'd2,
        ST_LOCK   = 3'd3,
        ST_ERROR  = 3'd4
    } state_t;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        if (v == 8'hFF) begin
            return v;
        end else begin
            return v + 8'd1;
        end
    endfunction

    state_t            state_q, state_d;
    logic [PEND_W-1:0] pend_q, pend_d;
    logic [LOCK_W-1:0] lock_q, lock_d;
    logic              read_submit_q, read_submit_d;
    logic              pending_err_q, pending_err_d;
    logic [N_CH-1:0]   missing_q, missing_d;
    logic [CNT_W-1:0]  sub_cnt_q, sub_cnt_d;
    logic [7:0]        err_cnt_q, err_cnt_d;

    logic [N_CH-1:0]   active_s;
    logic [N_CH-1:0]   eff_s;
    logic              all_ready_s;
    logic              any_req_s;

    // Qualify requests against the channel mask.
    always_comb begin
        active_s    = ~input_mask;
        eff_s       = request & active_s;
        all_ready_s = (active_s != '0) && (eff_s == active_s);
        any_req_s   = |eff_s;
    end

    // Next-state, counter and registered-output logic.
    always_comb begin
        state_d       = state_q;
        pend_d        = pend_q;
        lock_d        = lock_q;
        missing_d     = missing_q;
        sub_cnt_d     = sub_cnt_q;
        err_cnt_d     = err_cnt_q;
        read_submit_d = 1'b0;
        pending_err_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (all_ready_s) begin
                    state_d = ST_SUBMIT;
                end else if (any_req_s) begin
                    state_d = ST_WAIT;
                    pend_d  = PEND_W'(1);
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (all_ready_s) begin
                    state_d = ST_SUBMIT;
                    pend_d  = '0;
                end else if (live_rising || !any_req_s) begin
                    state_d = ST_IDLE;
                    pend_d  = '0;
                end else if (pend_q == PEND_MAX) begin
                    state_d   = ST_ERROR;
                    missing_d = active_s & ~request;
                    err_cnt_d = sat_inc8(err_cnt_q);
                end else begin
                    pend_d = pend_q + PEND_W'(1);
                end
            end
            ST_SUBMIT: begin
                lock_d = '0;
                if (LOCK_TIME == 0) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_LOCK;
                end
            end
            ST_LOCK: begin
                // Leaving on LOCK_LAST makes the lockout exactly LOCK_TIME cycles.
                if (lock_q == LOCK_LAST) begin
                    state_d = ST_IDLE;
                    lock_d  = '0;
                end else begin
                    lock_d = lock_q + LOCK_W'(1);
                end
            end
            ST_ERROR: begin
                if (live_rising) begin
                    state_d   = ST_IDLE;
                    missing_d = '0;
                    pend_d    = '0;
                end else begin
                    state_d = ST_ERROR;
                end
            end
            default: begin
                state_d   = ST_IDLE;
                pend_d    = '0;
                lock_d    = '0;
                missing_d = '0;
            end
        endcase

        if (state_d == ST_SUBMIT) begin
            read_submit_d = 1'b1;
            sub_cnt_d     = sub_cnt_q + CNT_W'(1);
        end else begin
            read_submit_d = 1'b0;
        end

        if (state_d == ST_ERROR) begin
            pending_err_d = 1'b1;
        end else begin
            pending_err_d = 1'b0;
        end
    end

    // State, counters and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            pend_q        <= '0;
            lock_q        <= '0;
            read_submit_q <= 1'b0;
            pending_err_q <= 1'b0;
            missing_q     <= '0;
            sub_cnt_q     <= '0;
            err_cnt_q     <= 8'd0;
        end else begin
            state_q       <= state_d;
            pend_q        <= pend_d;
            lock_q        <= lock_d;
            read_submit_q <= read_submit_d;
            pending_err_q <= pending_err_d;
            missing_q     <= missing_d;
            sub_cnt_q     <= sub_cnt_d;
            err_cnt_q     <= err_cnt_d;
        end
    end

    assign read_submit  = read_submit_q;
    assign pending_err  = pending_err_q;
    assign missing_mask = missing_q;
    assign submit_count = sub_cnt_q;
    assign err_count    = err_cnt_q;

endmodule

// File: tb/tb_read_submitter_multi.sv
// Directed bench for read_submitter_multi (N_CH=16, MAX_PENDING_TIME=10, LOCK_TIME=30).
module tb_read_submitter_multi;

    logic        clk = 1'b0;
    logic        reset;
    logic        live_rising;
    logic [15:0] request;
    logic [15:0] input_mask;
    logic        read_submit;
    logic        pending_err;
    logic [15:0] missing_mask;
    logic [15:0] submit_count;
    logic [7:0]  err_count;

    int n_checks = 0;
    int n_fail   = 0;
    int pulses   = 0;
    int errs     = 0;
    int gap;

    read_submitter_multi #(
        .N_CH(16), .MAX_PENDING_TIME(10), .LOCK_TIME(30), .CNT_W(16)
    ) dut (
        .clk(clk), .reset(reset), .live_rising(live_rising),
        .request(request), .input_mask(input_mask),
        .read_submit(read_submit), .pending_err(pending_err),
        .missing_mask(missing_mask), .submit_count(submit_count),
        .err_count(err_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One clock; inputs and outputs are handled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
        pulses += int'(read_submit);
        errs   += int'(pending_err);
    endtask

    task automatic settle();
        request = 16'h0000;
        repeat (40) tick();
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_rs"},   {31'd0, read_submit}, 32'd0);
        check({tag, "_pe"},   {31'd0, pending_err}, 32'd0);
        check({tag, "_mm"},   {16'd0, missing_mask}, 32'd0);
        check({tag, "_sc"},   {16'd0, submit_count}, 32'd0);
        check({tag, "_ec"},   {24'd0, err_count}, 32'd0);
    endtask

    initial begin
        reset       = 1'b1;
        live_rising = 1'b0;
        request     = 16'h0000;
        input_mask  = 16'h0000;
        repeat (3) tick();
        check_all_zero("reset");
        reset = 1'b0;
        repeat (3) tick();

        // Nominal submit and lockout spacing.
        request = 16'hFFFF;
        tick();
        check("nom_rs", {31'd0, read_submit}, 32'd1);
        check("nom_sc", {16'd0, submit_count}, 32'd1);
        for (int p = 0; p < 2; p++) begin
            gap = 0;
            do begin
                tick();
                gap++;
            end while (!read_submit && gap < 100);
            check("lock_gap", gap, 32'd32);
            check("lock_sc", {16'd0, submit_count}, 32'(2 + p));
        end
        settle();

        // Masked channels are ignored.
        input_mask = 16'h00F0;
        request    = 16'hFF0F;
        tick();
        check("mask_a_rs", {31'd0, read_submit}, 32'd1);
        settle();
        request = 16'hFFFF;
        tick();
        check("mask_b_rs", {31'd0, read_submit}, 32'd1);
        check("mask_sc", {16'd0, submit_count}, 32'd5);
        settle();

        input_mask = 16'hFFFF;
        request    = 16'hFFFF;
        pulses = 0;
        errs   = 0;
        repeat (2000) tick();
        check("allmask_pulses", pulses, 32'd0);
        check("allmask_errs", errs, 32'd0);
        request = 16'h0000;
        tick();
        input_mask = 16'h0000;
        tick();

        // Timeout on a partial set.
        pulses  = 0;
        request = 16'hFFFE;
        repeat (10) tick();
        check("to_pe_early", {31'd0, pending_err}, 32'd0);
        tick();
        check("to_pe", {31'd0, pending_err}, 32'd1);
        check("to_mm", {16'd0, missing_mask}, 32'h0001);
        check("to_ec", {24'd0, err_count}, 32'd1);
        request = 16'hFFFF;
        repeat (5) tick();
        check("to_pulses", pulses, 32'd0);
        check("to_pe_held", {31'd0, pending_err}, 32'd1);
        live_rising = 1'b1;
        tick();
        live_rising = 1'b0;
        check("clr_pe", {31'd0, pending_err}, 32'd0);
        check("clr_mm", {16'd0, missing_mask}, 32'd0);
        tick();
        check("clr_rs", {31'd0, read_submit}, 32'd1);
        check("clr_sc", {16'd0, submit_count}, 32'd6);
        check("clr_ec", {24'd0, err_count}, 32'd1);
        settle();

        // all_ready on the timeout edge wins.
        request = 16'hFFFE;
        repeat (10) tick();
        request = 16'hFFFF;
        tick();
        check("bnd_rs", {31'd0, read_submit}, 32'd1);
        check("bnd_pe", {31'd0, pending_err}, 32'd0);
        settle();

        // live_rising on the timeout edge returns to IDLE without error.
        request = 16'hFFFE;
        repeat (10) tick();
        live_rising = 1'b1;
        tick();
        live_rising = 1'b0;
        check("bnd_live_pe", {31'd0, pending_err}, 32'd0);
        check("bnd_live_ec", {24'd0, err_count}, 32'd1);
        request = 16'h0000;
        repeat (2) tick();

        // all_ready together with live_rising in WAIT submits.
        request = 16'hFFFE;
        repeat (3) tick();
        request     = 16'hFFFF;
        live_rising = 1'b1;
        tick();
        live_rising = 1'b0;
        check("wait_live_rs", {31'd0, read_submit}, 32'd1);
        check("wait_live_sc", {16'd0, submit_count}, 32'd8);
        settle();

        // Dropping requests mid-WAIT restarts the timeout.
        request = 16'hFFFE;
        repeat (6) tick();
        request = 16'h0000;
        tick();
        request = 16'hFFFE;
        repeat (10) tick();
        check("restart_pe_early", {31'd0, pending_err}, 32'd0);
        tick();
        check("restart_pe", {31'd0, pending_err}, 32'd1);
        check("restart_ec", {24'd0, err_count}, 32'd2);
        request     = 16'h0000;
        live_rising = 1'b1;
        tick();
        live_rising = 1'b0;
        check("restart_clr", {31'd0, pending_err}, 32'd0);

        // Asynchronous reset during LOCK.
        request = 16'hFFFF;
        tick();
        check("rst_lock_sc", {16'd0, submit_count}, 32'd9);
        request = 16'h0000;
        repeat (3) tick();
        #2 reset = 1'b1;
        #1;
        check_all_zero("rst_lock");
        repeat (2) tick();
        reset = 1'b0;
        tick();

        // Asynchronous reset during ERROR, then a normal submit.
        request = 16'hFFFE;
        repeat (11) tick();
        check("rst_err_pe", {31'd0, pending_err}, 32'd1);
        check("rst_err_ec", {24'd0, err_count}, 32'd1);
        #2 reset = 1'b1;
        #1;
        check_all_zero("rst_err");
        request = 16'h0000;
        tick();
        reset = 1'b0;
        tick();
        request = 16'hFFFF;
        tick();
        check("post_rst_rs", {31'd0, read_submit}, 32'd1);
        check("post_rst_sc", {16'd0, submit_count}, 32'd1);
        tick();
        check("post_rst_rs_low", {31'd0, read_submit}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/read_submitter_multi.md
# read_submitter_multi

Parametrised read-submit controller for the event buffer readout path. It watches per-channel "event written" requests from N_CH input writers. When every unmasked channel is ready, it issues a one-cycle `read_submit`, then locks out for LOCK_TIME cycles. It times out channel sets that stay partially ready, reporting exactly which channels are missing, and keeps submit and error statistics for the slow-control readout.

## Interface
- N_CH, 16, number of input channels (≥1)
- MAX_PENDING_TIME, 1000, partial-request timeout in clocks (≥1)
- LOCK_TIME, 30, post-submit lockout in clocks (≥0)
- CNT_W, 16, width of `submit_count`
- clk  in  1  system clock; all logic on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- live_rising  in  1  one-cycle pulse when LIVE returns; clears errors
- request  in  N_CH  per-channel ready flags
- input_mask  in  N_CH  1 = channel disabled, ignored
- read_submit  out  1  one-cycle read request for next event
- pending_err  out  1  timeout error, held until cleared
- missing_mask  out  N_CH  channels not ready at timeout; held with pending_err
- submit_count  out  CNT_W  number of read_submit pulses issued; wraps
- err_count  out  8  number of timeouts; saturates at 255

## Operation
- Definitions:
  - active = ~input_mask
  - eff = request & active
  - all_ready = (active != 0) && (eff == active)
  - any_req = |eff
- Requests on masked channels are ignored.
- All outputs are registered.
- Reset values: state IDLE; all outputs 0; pending and lock counters 0.
- Counter widths: pending counter $clog2(MAX_PENDING_TIME+1), lock counter $clog2(LOCK_TIME+1).
- FSM states:
  - IDLE:
    - if all_ready → SUBMIT
    - else if any_req → WAIT with pend=1
    - live_rising has no effect.
  - WAIT, evaluated in priority order:
    - all_ready → SUBMIT
    - live_rising → IDLE, pend=0
    - !any_req → IDLE, pend=0
    - pend == MAX_PENDING_TIME → ERROR: capture missing_mask = active & ~request; err_count+1 (saturating)
    - otherwise pend+1
  - SUBMIT:
    - read_submit=1 for this single cycle; submit_count+1 (wraps).
    - Next state is LOCK with lock=0, or IDLE if LOCK_TIME==0.
  - LOCK:
    - request is ignored; lock increments.
    - Goes to IDLE at the edge where lock reaches LOCK_TIME-1, so LOCK lasts exactly LOCK_TIME cycles.
    - live_rising has no effect.
  - ERROR:
    - pending_err=1, read_submit=0, missing_mask held; requests ignored.
    - live_rising → IDLE, which clears pending_err, missing_mask and pend.
    - err_count is not cleared.
- active==0 (all channels masked): stays in IDLE and never submits or times out.
- input_mask may change at any time; it takes effect on the next sampled edge.
- Reset mid-operation (any state): everything returns to reset values asynchronously, and a read_submit in flight is truncated.

## Timing
- Submit latency: all_ready sampled at edge k (state IDLE or WAIT) → read_submit high for the cycle after edge k.
- Minimum spacing between read_submit pulses is LOCK_TIME+2 cycles; with LOCK_TIME=0 it is 2.
- Timeout timing:
  - pending_err rises after the (MAX_PENDING_TIME+1)-th consecutive edge that samples any_req && !all_ready.
  - It is visible one cycle after that edge.
  - missing_mask changes in the same cycle.
- Simultaneous events:
  - all_ready on the timeout edge → submit, no error.
  - all_ready and live_rising together in WAIT → submit.
  - live_rising together with the timeout edge → IDLE, no error.
- Clearing: pending_err falls the cycle after the edge that samples live_rising in ERROR.

## Test plan
- Nominal submit:
  - Stimulus: N_CH=16, mask=0x0000, request steps 0→0xFFFF at edge k.
  - Required: read_submit=1 only in cycle k+1; submit_count=1.
- Lockout:
  - Stimulus: LOCK_TIME=30, request held at 0xFFFF.
  - Required: pulses exactly 32 cycles apart; submit_count increments per pulse.
- Masking:
  - Stimulus: mask=0x00F0, request=0xFF0F, then request=0xFFFF.
  - Required: both submit.
  - Stimulus: mask=0xFFFF, request=0xFFFF.
  - Required: no submit and no error for 2000 cycles.
- Timeout:
  - Stimulus: MAX_PENDING_TIME=10, request=0xFFFE held.
  - Required: pending_err rises after the 11th sampling edge; missing_mask=0x0001; err_count=1; no read_submit.
  - Stimulus: then request=0xFFFF.
  - Required: still no submit.
  - Stimulus: live_rising pulse.
  - Required: error clears, then a submit follows.
- Boundary:
  - Stimulus: all_ready arrives on the timeout edge.
  - Required: submit, pending_err stays 0.
  - Stimulus: request drops to 0 mid-WAIT, then reasserts.
  - Required: the timeout count restarts.
- Reset:
  - Stimulus: assert reset asynchronously during LOCK and during ERROR.
  - Required: all outputs 0 immediately, including submit_count and err_count; normal submit works after reset release.
